// File: rtl/divclk_sched_if.sv
// Control and status bundle for the clock-divider scheduler.
// The master drives commands and the prescale setup; the slave returns ticks and status.
interface divclk_sched_if #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned DIV_W = 8
);
   logic             en_req;
   logic             start;
   logic             stop;
   logic             mode;
   logic [DIV_W-1:0] div_sel;
   logic [DIV_W-1:0] burst_len;
   logic             tick;
   logic [CNT_W-1:0] cnt;
   logic             wrap;
   logic             busy;
   logic             done;

   modport master (
      output en_req, start, stop, mode, div_sel, burst_len,
      input  tick, cnt, wrap, busy, done
   );

   modport slave (
      input  en_req, start, stop, mode, div_sel, burst_len,
      output tick, cnt, wrap, busy, done
   );
endinterface

// File: rtl/divclk_sched.sv
// Single-clock, clock-enable replacement for the ripple divider chain: a prescaler
// produces tick strobes and a tap counter, in continuous or fixed-length burst mode.
module divclk_sched #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned DIV_W = 8
) (
   input logic            clk,
   input logic            rst,
   divclk_sched_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] pre_q, pre_d;
   logic [DIV_W-1:0] rem_q, rem_d;
   logic [DIV_W-1:0] div_l_q, div_l_d;
   logic             mode_l_q, mode_l_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             advance;

   always_comb begin
      state_d  = state_q;
      pre_d    = pre_q;
      rem_d    = rem_q;
      div_l_d  = div_l_q;
      mode_l_d = mode_l_q;
      cnt_d    = cnt_q;
      tick_d   = 1'b0;
      wrap_d   = 1'b0;
      done_d   = 1'b0;
      advance  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.stop) begin
               // A zero-length burst completes immediately without ever running.
               if (bus.mode && (bus.burst_len == '0)) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = StRun;
                  pre_d    = bus.div_sel;
                  div_l_d  = bus.div_sel;
                  rem_d    = bus.burst_len;
                  mode_l_d = bus.mode;
                  cnt_d    = '0;
               end
            end
         end
         StRun: begin
            if (bus.stop) begin
               state_d = StIdle;
            end else if (!bus.en_req) begin
               state_d = StHold;
            end else begin
               advance = 1'b1;
            end
         end
         StHold: begin
            if (bus.stop) begin
               state_d = StIdle;
            end else if (bus.en_req) begin
               // Resume counting on this same edge so no enabled cycle is lost.
               state_d = StRun;
               advance = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         if (pre_q == '0) begin
            tick_d = 1'b1;
            pre_d  = div_l_q;
            cnt_d  = cnt_q + 1'b1;
            wrap_d = &cnt_q;
            if (mode_l_q) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == DIV_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end else begin
            pre_d = pre_q - 1'b1;
         end
      end
   end

   assign busy_d = (state_d != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         pre_q    <= '0;
         rem_q    <= '0;
         div_l_q  <= '0;
         mode_l_q <= 1'b0;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         wrap_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         rem_q    <= rem_d;
         div_l_q  <= div_l_d;
         mode_l_q <= mode_l_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         wrap_q   <= wrap_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.tick = tick_q;
   assign bus.cnt  = cnt_q;
   assign bus.wrap = wrap_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_divclk_sched.sv
// Self-checking bench for divclk_sched: a fixed vector table, directed corner sequences,
// and random stimulus compared against a tick-counting reference model.
module tb_divclk_sched;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DIV_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   divclk_sched_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

   divclk_sched #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model: counts enabled edges since start; a tick is every (div+1)th one.
   bit          m_run;
   int unsigned m_en_n, m_ticks, m_div, m_blen;
   bit          m_mode;
   bit          e_tick, e_wrap, e_done, e_busy;
   int unsigned e_cnt;

   task automatic model_step();
      e_tick = 0;
      e_wrap = 0;
      e_done = 0;
      if (rst) begin
         m_run = 0;
         e_cnt = 0;
      end else if (!m_run) begin
         if (bus.start && !bus.stop) begin
            if (bus.mode && bus.burst_len == 0) begin
               e_done = 1;
            end else begin
               m_run   = 1;
               m_div   = bus.div_sel;
               m_blen  = bus.burst_len;
               m_mode  = bus.mode;
               m_en_n  = 0;
               m_ticks = 0;
               e_cnt   = 0;
            end
         end
      end else if (bus.stop) begin
         m_run = 0;
      end else if (bus.en_req) begin
         m_en_n++;
         if (m_en_n % (m_div + 1) == 0) begin
            m_ticks++;
            e_tick = 1;
            e_cnt  = m_ticks % (1 << CNT_W);
            e_wrap = (e_cnt == 0);
            if (m_mode && m_ticks == m_blen) begin
               e_done = 1;
               m_run  = 0;
            end
         end
      end
      e_busy = m_run;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_model(string tag);
      chk({tag, ".tick"}, 32'(bus.tick), 32'(e_tick));
      chk({tag, ".wrap"}, 32'(bus.wrap), 32'(e_wrap));
      chk({tag, ".done"}, 32'(bus.done), 32'(e_done));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
      chk({tag, ".cnt"},  32'(bus.cnt),  32'(e_cnt));
   endtask

   task automatic drive(bit r, bit st, bit sp, bit en, bit md, int unsigned dv, int unsigned bl);
      rst           = r;
      bus.start     = st;
      bus.stop      = sp;
      bus.en_req    = en;
      bus.mode      = md;
      bus.div_sel   = DIV_W'(dv);
      bus.burst_len = DIV_W'(bl);
   endtask

   // One clock: the model sees the same inputs as the DUT; outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   typedef struct {
      bit r, st, sp, en, md;
      int unsigned dv, bl;
      bit x_tick, x_wrap, x_done, x_busy;
      int unsigned x_cnt;
   } vec_t;

   vec_t vt[$];
   int   n_tick, n_wrap, n_done;

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      // r st sp en md dv bl | tick wrap done busy cnt
      vt.push_back('{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{0, 1, 0, 1, 1, 1, 2, 0, 0, 0, 1, 0});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1});
      vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 2});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2});
      vt.push_back('{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2});
      vt.push_back('{0, 1, 0, 1, 1, 3, 0, 0, 0, 1, 0, 2});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2});
      vt.push_back('{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1});
      vt.push_back('{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1});

      foreach (vt[i]) begin
         drive(vt[i].r, vt[i].st, vt[i].sp, vt[i].en, vt[i].md, vt[i].dv, vt[i].bl);
         step();
         chk($sformatf("vec%0d.tick", i), 32'(bus.tick), 32'(vt[i].x_tick));
         chk($sformatf("vec%0d.wrap", i), 32'(bus.wrap), 32'(vt[i].x_wrap));
         chk($sformatf("vec%0d.done", i), 32'(bus.done), 32'(vt[i].x_done));
         chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vt[i].x_busy));
         chk($sformatf("vec%0d.cnt", i),  32'(bus.cnt),  32'(vt[i].x_cnt));
      end

      // Continuous, div_sel=0: sixteen ticks, exactly one wrap.
      drive(0, 1, 0, 1, 0, 0, 0);
      step();
      chk_model("cont.start");
      drive(0, 0, 0, 1, 0, 0, 0);
      n_wrap = 0;
      n_tick = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         chk_model($sformatf("cont%0d", i));
         n_wrap += int'(bus.wrap);
         n_tick += int'(bus.tick);
      end
      chk("cont.ticks", 32'(n_tick), 32'd16);
      chk("cont.wraps", 32'(n_wrap), 32'd1);

      // Reset mid-run for two cycles with start asserted.
      drive(1, 1, 0, 1, 0, 0, 0);
      step();
      step();
      chk_model("rst");
      chk("rst.busy", 32'(bus.busy), 32'd0);
      drive(0, 0, 0, 1, 0, 0, 0);
      step();
      chk_model("rst.after");

      // Burst, div_sel=3, burst_len=5.
      drive(0, 1, 0, 1, 1, 3, 5);
      step();
      drive(0, 0, 0, 1, 0, 0, 0);
      n_tick = 0;
      n_done = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         chk_model($sformatf("burst%0d", i));
         n_tick += int'(bus.tick);
         n_done += int'(bus.done);
         if (bus.done) chk("burst.done_with_tick", 32'(bus.tick), 32'd1);
      end
      chk("burst.ticks", 32'(n_tick), 32'd5);
      chk("burst.dones", 32'(n_done), 32'd1);
      chk("burst.cnt", 32'(bus.cnt), 32'd5);

      // Hold: div_sel=2, en_req low for 3 cycles mid-period.
      drive(0, 1, 0, 1, 0, 2, 0);
      step();
      for (int i = 0; i < 14; i++) begin
         drive(0, 0, 0, !(i >= 4 && i < 7), 0, 0, 0);
         step();
         chk_model($sformatf("hold%0d", i));
      end
      drive(0, 0, 1, 1, 0, 0, 0);
      step();
      chk_model("hold.stop");

      // Stop on the edge where a tick is due, then restart one cycle later.
      drive(0, 1, 0, 1, 0, 1, 0);
      step();
      drive(0, 0, 0, 1, 0, 0, 0);
      step();
      drive(0, 0, 1, 1, 0, 0, 0);
      step();
      chk_model("stopdue");
      chk("stopdue.tick", 32'(bus.tick), 32'd0);
      drive(0, 1, 0, 1, 0, 1, 0);
      step();
      chk_model("restart");
      chk("restart.cnt", 32'(bus.cnt), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 97) == 0, ($urandom % 8) == 0, ($urandom % 20) == 0,
               ($urandom % 4) != 0, $urandom % 2, $urandom_range(0, 3), $urandom_range(0, 5));
         step();
         chk_model($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
